// File: rtl/step_phase_sequencer.sv
// Stepper motor phase sequencer: divides the system clock down to a step rate and
// walks an 8-entry half-step table, driving coils, a step strobe and a position count.
module step_phase_sequencer #(
    parameter int                CNT_W              = 24,
    parameter int                POS_W              = 16,
    parameter logic [CNT_W-1:0]  RESET_MAX          = 24'h16e360,
    parameter bit                HOLD_WHEN_DISABLED = 1'b1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             enable,
    input  logic             dir,
    input  logic             full_step,
    input  logic [CNT_W-1:0] max_count,
    output logic [3:0]       coils,
    output logic             step_pulse,
    output logic [2:0]       phase_idx,
    output logic [POS_W-1:0] position
);

    logic [CNT_W-1:0] div_cnt;
    logic [CNT_W-1:0] period_q;
    logic             terminal;
    logic             tick;
    logic [2:0]       step_size;
    logic [2:0]       next_phase;

    function automatic logic [3:0] phase_pattern(input logic [2:0] idx);
        case (idx)
            3'd0:    phase_pattern = 4'b1000;
            3'd1:    phase_pattern = 4'b1100;
            3'd2:    phase_pattern = 4'b0100;
            3'd3:    phase_pattern = 4'b0110;
            3'd4:    phase_pattern = 4'b0010;
            3'd5:    phase_pattern = 4'b0011;
            3'd6:    phase_pattern = 4'b0001;
            default: phase_pattern = 4'b1001;
        endcase
    endfunction

    // Periods of 0 or 1 collapse to a tick every cycle; the <= 1 guard also keeps
    // period_q-1 from underflowing.  Full step from an even index realigns by one.
    always_comb begin
        terminal   = (period_q <= CNT_W'(1)) || (div_cnt >= period_q - CNT_W'(1));
        tick       = enable && terminal;
        step_size  = (full_step && phase_idx[0]) ? 3'd2 : 3'd1;
        next_phase = dir ? (phase_idx + step_size) : (phase_idx - step_size);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            div_cnt    <= '0;
            period_q   <= RESET_MAX;
            phase_idx  <= 3'd0;
            coils      <= 4'b0000;
            step_pulse <= 1'b0;
            position   <= '0;
        end else begin
            step_pulse <= tick;
            if (!enable) begin
                // While stopped the period tracks max_count so a restart uses the newest speed.
                div_cnt  <= '0;
                period_q <= max_count;
                if (!HOLD_WHEN_DISABLED) begin
                    coils <= 4'b0000;
                end
            end else if (tick) begin
                div_cnt   <= '0;
                period_q  <= max_count;
                phase_idx <= next_phase;
                position  <= dir ? (position + POS_W'(1)) : (position - POS_W'(1));
                coils     <= phase_pattern(next_phase);
            end else begin
                div_cnt <= div_cnt + CNT_W'(1);
                coils   <= phase_pattern(phase_idx);
            end
        end
    end

endmodule

// File: tb/tb_step_phase_sequencer.sv
// Bench for step_phase_sequencer: directed scenarios plus randomized stimulus, checked
// every cycle against a cycle-counting model of the stepper behaviour.
module tb_step_phase_sequencer;

    localparam int CNT_W = 24;
    localparam int POS_W = 16;
    localparam int RESET_MAX = 'h16e360;
    localparam logic [3:0] TABLE [8] = '{4'b1000, 4'b1100, 4'b0100, 4'b0110,
                                         4'b0010, 4'b0011, 4'b0001, 4'b1001};

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic             enable = 1'b0;
    logic             dir = 1'b1;
    logic             full_step = 1'b0;
    logic [CNT_W-1:0] max_count = '0;
    logic [3:0]       coils_h, coils_z;
    logic             step_pulse, step_pulse_z;
    logic [2:0]       phase_idx, phase_idx_z;
    logic [POS_W-1:0] position, position_z;

    int test_count = 0;
    int fail_count = 0;
    bit check_on = 1'b0;

    // Model state: cycles elapsed in the current period, latched period, phase, position.
    int         m_elapsed, m_period, m_phase, m_pos;
    logic [3:0] m_coils_h, m_coils_z;
    logic       m_pulse;

    step_phase_sequencer #(.HOLD_WHEN_DISABLED(1'b1)) dut_hold (
        .clk(clk), .rst(rst), .enable(enable), .dir(dir), .full_step(full_step),
        .max_count(max_count), .coils(coils_h), .step_pulse(step_pulse),
        .phase_idx(phase_idx), .position(position)
    );

    step_phase_sequencer #(.HOLD_WHEN_DISABLED(1'b0)) dut_zero (
        .clk(clk), .rst(rst), .enable(enable), .dir(dir), .full_step(full_step),
        .max_count(max_count), .coils(coils_z), .step_pulse(step_pulse_z),
        .phase_idx(phase_idx_z), .position(position_z)
    );

    always #10 clk = ~clk;

    always @(posedge clk or posedge rst) begin : model
        int eff;
        int stp;
        if (rst) begin
            m_elapsed <= 0;
            m_period  <= RESET_MAX;
            m_phase   <= 0;
            m_pos     <= 0;
            m_coils_h <= 4'b0000;
            m_coils_z <= 4'b0000;
            m_pulse   <= 1'b0;
        end else if (enable) begin
            eff = (m_period < 1) ? 1 : m_period;
            if (m_elapsed + 1 >= eff) begin
                stp = (full_step && (m_phase % 2 == 1)) ? 2 : 1;
                stp = dir ? stp : 8 - stp;
                m_phase   <= (m_phase + stp) % 8;
                m_pos     <= (m_pos + (dir ? 1 : -1)) & 'hFFFF;
                m_elapsed <= 0;
                m_period  <= int'(max_count);
                m_pulse   <= 1'b1;
                m_coils_h <= TABLE[(m_phase + stp) % 8];
                m_coils_z <= TABLE[(m_phase + stp) % 8];
            end else begin
                m_elapsed <= m_elapsed + 1;
                m_pulse   <= 1'b0;
                m_coils_h <= TABLE[m_phase];
                m_coils_z <= TABLE[m_phase];
            end
        end else begin
            m_elapsed <= 0;
            m_period  <= int'(max_count);
            m_pulse   <= 1'b0;
            m_coils_z <= 4'b0000;
        end
    end

    task automatic check_output(input string name, input int actual, input int expected);
        test_count++;
        if (actual !== expected) begin
            fail_count++;
            $display("[TB] FAIL %s: got %0h, expected %0h at %0t", name, actual, expected, $time);
        end
    endtask

    always @(negedge clk) begin
        if (check_on) begin
            check_output("coils_hold", int'(coils_h), int'(m_coils_h));
            check_output("coils_zero", int'(coils_z), int'(m_coils_z));
            check_output("step_pulse", int'(step_pulse), int'(m_pulse));
            check_output("phase_idx", int'(phase_idx), m_phase);
            check_output("position", int'(position), m_pos);
            check_output("phase_idx_zero_inst", int'(phase_idx_z), m_phase);
        end
    end

    task automatic apply_reset();
        @(negedge clk);
        rst = 1'b1;
        enable = 1'b0;
        @(negedge clk);
        rst = 1'b0;
    endtask

    // Counts negedges until step_pulse is seen, bounded so a dead DUT cannot hang the run.
    task automatic wait_pulse(output int n);
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!step_pulse && n < 2000);
        if (!step_pulse) check_output("pulse_timeout", 0, 1);
    endtask

    task automatic apply_stimulus(input int cycles);
        for (int i = 0; i < cycles; i++) begin
            @(negedge clk);
            rst = ($urandom % 500 == 0);
            if ($urandom % 50 == 0) max_count = CNT_W'($urandom_range(0, 6));
            if ($urandom % 16 == 0) enable = ($urandom % 6 != 0);
            if ($urandom % 4 == 0) dir = $urandom % 2;
            if ($urandom % 4 == 0) full_step = $urandom % 2;
        end
    endtask

    initial begin : main
        int n;
        int pulses;
        logic [3:0] held;
        logic [3:0] exp_half [8] = '{4'b1100, 4'b0100, 4'b0110, 4'b0010,
                                     4'b0011, 4'b0001, 4'b1001, 4'b1000};
        int exp_full [5] = '{1, 3, 5, 7, 1};

        apply_reset();
        check_on = 1'b1;
        check_output("reset_coils_hold", int'(coils_h), 0);
        check_output("reset_coils_zero", int'(coils_z), 0);
        check_output("reset_position", int'(position), 0);
        check_output("reset_phase", int'(phase_idx), 0);

        // Idle with enable low: nothing may move.
        max_count = 24'd4;
        pulses = 0;
        repeat (100) begin
            @(negedge clk);
            if (step_pulse) pulses++;
        end
        check_output("idle_pulses", pulses, 0);
        check_output("idle_coils_hold", int'(coils_h), 0);

        enable = 1'b1; dir = 1'b1; full_step = 1'b0;
        for (int k = 0; k < 8; k++) begin
            wait_pulse(n);
            check_output("half_fwd_interval", n, 4);
            check_output("half_fwd_coils", int'(coils_h), int'(exp_half[k]));
        end
        check_output("half_fwd_position", int'(position), 8);

        apply_reset();
        max_count = 24'd3; full_step = 1'b1; dir = 1'b1;
        @(negedge clk);
        enable = 1'b1;
        for (int k = 0; k < 5; k++) begin
            wait_pulse(n);
            check_output("full_fwd_interval", n, 3);
            check_output("full_fwd_phase", int'(phase_idx), exp_full[k]);
        end

        apply_reset();
        max_count = 24'd2; dir = 1'b0; full_step = 1'b0;
        @(negedge clk);
        enable = 1'b1;
        wait_pulse(n);
        check_output("rev_phase_wrap", int'(phase_idx), 7);
        check_output("rev_position_wrap", int'(position), 'hFFFF);
        wait_pulse(n);
        check_output("rev_phase_next", int'(phase_idx), 6);
        check_output("rev_position_next", int'(position), 'hFFFE);

        apply_reset();
        dir = 1'b1; full_step = 1'b0;
        @(negedge clk);
        enable = 1'b1;
        wait_pulse(n);
        check_output("to_index_one", int'(phase_idx), 1);
        dir = 1'b0; full_step = 1'b1;
        wait_pulse(n);
        check_output("full_rev_1_to_7", int'(phase_idx), 7);
        check_output("full_rev_coils", int'(coils_h), 'b1001);

        // Speed change mid-period takes effect only at the next boundary.
        apply_reset();
        max_count = 24'd10; dir = 1'b1; full_step = 1'b0;
        @(negedge clk);
        enable = 1'b1;
        repeat (3) @(negedge clk);
        max_count = 24'd2;
        wait_pulse(n);
        check_output("midchange_first", n + 3, 10);
        wait_pulse(n);
        check_output("midchange_second", n, 2);
        max_count = 24'd0;
        wait_pulse(n);
        check_output("to_zero_boundary", n, 2);
        wait_pulse(n);
        check_output("zero_every_clock_a", n, 1);
        wait_pulse(n);
        check_output("zero_every_clock_b", n, 1);

        max_count = 24'd5;
        wait_pulse(n);
        wait_pulse(n);
        check_output("period_five", n, 5);
        repeat (2) @(negedge clk);
        held = m_coils_h;
        enable = 1'b0;
        pulses = 0;
        repeat (20) begin
            @(negedge clk);
            if (step_pulse) pulses++;
        end
        check_output("disabled_pulses", pulses, 0);
        check_output("disabled_hold", int'(coils_h), int'(held));
        check_output("disabled_zero", int'(coils_z), 0);
        enable = 1'b1;
        @(negedge clk);
        check_output("reenable_zero_coils", int'(coils_z), int'(TABLE[m_phase]));
        wait_pulse(n);
        check_output("reenable_first_period", n + 1, 5);

        @(posedge clk);
        #3 rst = 1'b1;
        #1;
        check_output("async_rst_coils", int'(coils_h), 0);
        check_output("async_rst_phase", int'(phase_idx), 0);
        check_output("async_rst_position", int'(position), 0);
        @(negedge clk);
        rst = 1'b0;

        max_count = 24'd3;
        apply_stimulus(4000);
        rst = 1'b0;
        repeat (2) @(negedge clk);

        $display("[TB] %0d tests run, %0d failed", test_count, fail_count);
        $finish;
    end

endmodule

// File: doc/step_phase_sequencer.md
Name: step_phase_sequencer

Overview:
- Downstream consumer of the speed/step-size lookup stage's 24-bit max count.
- Divides the 50 MHz clock down to a step rate and steps an 8-entry half-step phase table.
- Supports full-step and half-step modes and forward/reverse direction.
- Drives the 4 motor coil lines, emits a one-cycle step strobe and keeps a signed step position count.

Parameters:
- CNT_W, 24, width of max_count and the internal divider counter.
- POS_W, 16, width of the signed position counter.
- RESET_MAX, 24'h16e360, value loaded into the period register at reset (slowest full-step speed).
- HOLD_WHEN_DISABLED, 1, 1 = coils keep the current pattern while disabled; 0 = coils driven 4'b0000 while disabled.

Ports:
- clk  in  1  system clock, 50 MHz.
- rst  in  1  asynchronous, active-high reset.
- enable  in  1  1 = run; 0 = stop stepping.
- dir  in  1  1 = forward (phase index increments); 0 = reverse.
- full_step  in  1  1 = full step; 0 = half step.
- max_count  in  CNT_W  clocks per step period, from the upstream lookup stage.
- coils  out  4  coil drive pattern {A,B,C,D}, registered.
- step_pulse  out  1  one-cycle strobe, high in the cycle the new coil pattern first appears.
- phase_idx  out  3  current phase table index, registered.
- position  out  POS_W  signed step count, registered.

Behaviour:
- Reset (async, rst=1): div_cnt=0, period_q=RESET_MAX, phase_idx=0, coils=4'b0000, step_pulse=0, position=0.
- Phase table, index 0..7: 1000, 1100, 0100, 0110, 0010, 0011, 0001, 1001.
- Period register: period_q loads max_count on every terminal cycle and on every cycle while enable=0. A max_count change mid-period therefore takes effect only at the next period boundary.
- Divider, enable=1:
  - Terminal condition: div_cnt >= period_q-1, or period_q <= 1.
  - On terminal: div_cnt <= 0 and a tick is issued; otherwise div_cnt increments.
  - A period_q of 0 or 1 gives a tick every cycle.
  - Step period is therefore max(period_q,1) clocks.
- enable=0: div_cnt held at 0, no ticks. phase_idx and position retained.
- Tick handling, all at the same clock edge:
  - Phase step size:
    - half step: ±1;
    - full step with phase_idx odd: ±2 (stays on two-coil entries);
    - full step with phase_idx even: ±1 (realigns to an odd index).
  - Sign of the phase step: + when dir=1, - when dir=0. The index wraps modulo 8 (7+1→0, 0-1→7, 7+2→1, 1-2→7).
  - position += 1 (dir=1) or -= 1 (dir=0) per tick, wrapping modulo 2^POS_W.
  - step_pulse set to 1 for exactly one cycle.
- coils is registered:
  - enable=1: table[next phase_idx].
  - enable=0: table[phase_idx] if HOLD_WHEN_DISABLED=1, else 4'b0000.
  - Latency from enable rising to coils showing table[phase_idx]: one clock.
- dir and full_step are sampled only on tick cycles. Changing either mid-period is legal and affects the next tick only.
- enable falling in the same cycle as a terminal count: no tick, because enable=0 gates it.
- Reset asserted mid-operation: all state returns to reset values immediately (async). The first tick after release occurs RESET_MAX clocks after enable=1 and rst=0, unless max_count was loaded while disabled.

Test Plan:
- Reset/idle: rst=1 then 0, enable=0 → coils=0000 (both parameter settings), position=0, phase_idx=0, no step_pulse for 100 clocks.
- Half step forward: max_count=4, enable=1, dir=1, full_step=0 →
  - step_pulse every 4 clocks;
  - coils sequence 1100, 0100, 0110, 0010, 0011, 0001, 1001, 1000;
  - position=8 after 8 pulses.
- Full step with alignment: phase_idx=0, full_step=1, dir=1, max_count=3 → phase_idx 1, 3, 5, 7, 1, ... with a pulse every 3 clocks.
- Reverse wrap: phase_idx=0, dir=0, half step → phase_idx 7, 6, ...; position=0 → -1 (16'hFFFF); a full step from index 1 → 7.
- Mid-period speed change: max_count 10→2 at div_cnt=3 → current period completes at 10 clocks, following periods are 2 clocks. max_count=0 → a pulse every clock.
- Disable/hold: enable 1→0 mid-period → no further pulses, coils hold (HOLD=1) or go 0000 (HOLD=0). Re-enable → coils = table[phase_idx] after 1 clock, first pulse after a full max_count period. Async rst mid-run → all outputs at reset values before the next clk edge.
